// File: rtl/tex_qspi_pkg.sv
// Shared types and constants for the texture QSPI reader: FSM states, phase lengths, grant encoding.
package tex_qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam int CMD_CLKS   = 8;
    localparam int ADDR_CLKS  = 24;
    localparam int GAP_CYCLES = 2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/tex_qspi_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant from the request vector, last-served pointer advanced on update.
module tex_qspi_rr_arb
    import tex_qspi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_served;

    always_comb begin
        grant = GNT_NONE;
        if (req == 2'b11) begin
            grant = last_served ? GNT_0 : GNT_1;
        end else if (req[0]) begin
            grant = GNT_0;
        end else if (req[1]) begin
            grant = GNT_1;
        end
    end

    // Reset value 1 means requester 1 was "last served", so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served <= 1'b1;
        end else if (update && (grant != GNT_NONE)) begin
            last_served <= grant[1];
        end
    end

endmodule

// File: rtl/tex_qspi_reader.sv
// Texture ROM reader: arbitrates two requesters onto the shared QSPI pads and runs a 0x6B quad-output read.
// Optional build macro TEX_QSPI_PERF_CNT_EN adds o_xfer_count, a wrapping count of completed reads.
module tex_qspi_reader
    import tex_qspi_pkg::*;
#(
    parameter int         DATA_BITS  = 8,
    parameter int         DUMMY_CLKS = 8,
    parameter logic [7:0] CMD_BYTE   = 8'h6B
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_req,
    input  logic [23:0]          i_addr0,
    input  logic [23:0]          i_addr1,
    output logic [1:0]           o_ack,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_busy,
    output logic                 o_tex_csb,
    output logic                 o_tex_sclk,
    output logic                 o_tex_oeb0,
    output logic                 o_tex_out0,
    input  logic [3:0]           i_tex_in
`ifdef TEX_QSPI_PERF_CNT_EN
    ,
    output logic [15:0]          o_xfer_count
`endif
);

    state_t               state, state_d;
    logic                 lead;
    logic [7:0]           cnt;
    logic [7:0]           state_len;
    logic                 last_period;
    logic                 period_end;
    logic                 accept;
    logic                 advance;
    logic                 ack_set;
    logic [1:0]           grant;
    logic [1:0]           gnt_q;
    logic [31:0]          sr;
    logic [DATA_BITS-1:0] dsr;
    logic [DATA_BITS-1:0] dsr_next;

    tex_qspi_rr_arb u_arb (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .req    (i_req),
        .update (accept),
        .grant  (grant)
    );

    // cnt counts SCLK periods in the shifting states and plain cycles in GAP.
    always_comb begin
        case (state)
            ST_CMD:   state_len = 8'(CMD_CLKS);
            ST_ADDR:  state_len = 8'(ADDR_CLKS);
            ST_DUMMY: state_len = 8'(DUMMY_CLKS);
            ST_DATA:  state_len = 8'(DATA_BITS / 4);
            ST_GAP:   state_len = 8'(GAP_CYCLES);
            default:  state_len = 8'd1;
        endcase
    end

    assign last_period = (cnt == state_len - 8'd1);
    assign period_end  = (state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA}) && !lead && o_tex_sclk;
    assign dsr_next    = DATA_BITS'({dsr, i_tex_in});
    assign ack_set     = advance && (state == ST_DATA);
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        advance = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|i_req) begin
                    accept  = 1'b1;
                    state_d = ST_CMD;
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                if (period_end && last_period) begin
                    advance = 1'b1;
                    case (state)
                        ST_CMD:   state_d = ST_ADDR;
                        ST_ADDR:  state_d = ST_DUMMY;
                        ST_DUMMY: state_d = ST_DATA;
                        default:  state_d = ST_GAP;
                    endcase
                end
            end
            ST_GAP: begin
                if (last_period) begin
                    advance = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The cycle after accept is a lead-in: pads stay idle, then csb falls with the first
    // command bit already on io0, giving a full low phase of setup before the first rising SCLK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lead       <= 1'b0;
            cnt        <= '0;
            gnt_q      <= GNT_NONE;
            o_ack      <= GNT_NONE;
            o_data     <= '0;
            o_tex_csb  <= 1'b1;
            o_tex_sclk <= 1'b0;
            o_tex_oeb0 <= 1'b1;
            o_tex_out0 <= 1'b0;
        end else begin
            o_ack <= GNT_NONE;
            if (accept) begin
                lead  <= 1'b1;
                cnt   <= '0;
                gnt_q <= grant;
            end else if (lead) begin
                lead       <= 1'b0;
                o_tex_csb  <= 1'b0;
                o_tex_sclk <= 1'b0;
                o_tex_oeb0 <= 1'b0;
                o_tex_out0 <= sr[31];
            end else if (state == ST_GAP) begin
                cnt <= advance ? '0 : cnt + 8'd1;
            end else if (state != ST_IDLE) begin
                o_tex_sclk <= ~o_tex_sclk;
                if (period_end) begin
                    cnt <= advance ? '0 : cnt + 8'd1;
                    case (state_d)
                        ST_CMD, ST_ADDR: o_tex_out0 <= sr[30];
                        ST_DUMMY: begin
                            o_tex_oeb0 <= 1'b1;
                            o_tex_out0 <= 1'b0;
                        end
                        ST_GAP: begin
                            o_tex_csb  <= 1'b1;
                            o_tex_sclk <= 1'b0;
                            o_ack      <= gnt_q;
                            o_data     <= dsr_next;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Shift registers carry no reset: they are always loaded before use.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            sr <= {CMD_BYTE, grant[1] ? i_addr1 : i_addr0};
        end else if (period_end) begin
            sr <= sr << 1;
        end
        if (period_end && (state == ST_DATA)) begin
            dsr <= dsr_next;
        end
    end

`ifdef TEX_QSPI_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_xfer_count <= '0;
        end else if (ack_set) begin
            o_xfer_count <= o_xfer_count + 16'd1;
        end
    end
`endif

endmodule
